// File: rtl/branch_pred_unit.sv
// branch_pred_unit -- fetch-stage branch predictor.
//   Direct-mapped BTB (valid/tag/target/counter/type per entry) plus a
//   circular return-address stack. Predictions are combinational from
//   registered state; updates from ID land on the next rising edge.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   if_pc             fetch PC to predict for
//   pred_taken        fetch PC predicted to redirect
//   pred_pc           predicted next fetch PC
//   btb_hit           if_pc matches a valid BTB entry
//   upd_valid         resolved branch/jal/jalr this cycle
//   upd_pc            PC of the resolved instruction
//   upd_target        resolved target
//   upd_taken         resolved instruction was taken
//   upd_type          0 cond branch, 1 jump, 2 call, 3 return
//   mispredict_cnt    number of updates that disagreed with the stored prediction
module branch_pred_unit #(
  parameter int ENTRIES   = 16,
  parameter int CNT_W     = 2,
  parameter int RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_pc,
  output logic        btb_hit,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  input  logic [1:0]  upd_type,
  output logic [31:0] mispredict_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int OCC_W = $clog2(RAS_DEPTH + 1);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(1) << (CNT_W - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(RAS_DEPTH);

  typedef enum logic [1:0] {
    BR_COND = 2'd0,
    BR_JUMP = 2'd1,
    BR_CALL = 2'd2,
    BR_RET  = 2'd3
  } br_type_e;

  logic                 valid_q  [ENTRIES];
  logic [TAG_W-1:0]     tag_q    [ENTRIES];
  logic [31:0]          target_q [ENTRIES];
  logic [CNT_W-1:0]     cnt_q    [ENTRIES];
  br_type_e             type_q   [ENTRIES];

  logic [31:0]          ras_q    [RAS_DEPTH];
  logic [PTR_W-1:0]     ras_ptr_q;
  logic [OCC_W-1:0]     ras_occ_q;
  logic [31:0]          mcnt_q;

  logic [IDX_W-1:0]     rd_idx, up_idx;
  logic [TAG_W-1:0]     rd_tag, up_tag;
  logic [PTR_W-1:0]     ras_top_idx;
  logic                 up_hit, up_pred, up_mispred;
  logic [CNT_W-1:0]     up_cnt_next;
  br_type_e             up_type;
  logic                 unused_ok;

  assign unused_ok = ^{if_pc[1:0], upd_pc[1:0]};

  // Fetch-side lookup
  assign rd_idx = if_pc[IDX_W+1:2];
  assign rd_tag = if_pc[31:IDX_W+2];

  // ras_ptr_q points at the next free slot; the top is one below it.
  assign ras_top_idx = (ras_ptr_q == '0) ? PTR_LAST : ras_ptr_q - PTR_W'(1);

  always_comb begin
    btb_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    pred_taken = btb_hit && ((type_q[rd_idx] != BR_COND) || cnt_q[rd_idx][CNT_W-1]);
    pred_pc    = if_pc + 32'd4;
    if (pred_taken) begin
      if (type_q[rd_idx] == BR_RET && ras_occ_q != '0)
        pred_pc = ras_q[ras_top_idx];
      else
        pred_pc = target_q[rd_idx];
    end
  end

  // Update-side lookup, evaluated against the pre-update state
  assign up_idx  = upd_pc[IDX_W+1:2];
  assign up_tag  = upd_pc[31:IDX_W+2];
  assign up_type = br_type_e'(upd_type);

  always_comb begin
    up_hit  = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    up_pred = up_hit && ((type_q[up_idx] != BR_COND) || cnt_q[up_idx][CNT_W-1]);
    up_mispred = (up_pred != upd_taken) ||
                 (up_pred && upd_taken && (target_q[up_idx] != upd_target));
    up_cnt_next = cnt_q[up_idx];
    if (upd_taken) begin
      if (cnt_q[up_idx] != CNT_MAX) up_cnt_next = cnt_q[up_idx] + CNT_W'(1);
    end else begin
      if (cnt_q[up_idx] != '0) up_cnt_next = cnt_q[up_idx] - CNT_W'(1);
    end
  end

  // Valid bits, RAS bookkeeping and the counter are the only reset state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
      ras_ptr_q <= '0;
      ras_occ_q <= '0;
      mcnt_q    <= '0;
    end else if (upd_valid) begin
      if (up_mispred) mcnt_q <= mcnt_q + 32'd1;
      if (up_hit) begin
        if (up_type == BR_COND) cnt_q[up_idx] <= up_cnt_next;
        if (upd_taken) target_q[up_idx] <= upd_target;
        type_q[up_idx] <= up_type;
      end else if (upd_taken) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= upd_target;
        type_q[up_idx]   <= up_type;
        cnt_q[up_idx]    <= CNT_INIT;
      end
      // A push when full overwrites the oldest slot; occupancy saturates.
      if (up_type == BR_CALL) begin
        ras_q[ras_ptr_q] <= upd_pc + 32'd4;
        ras_ptr_q <= (ras_ptr_q == PTR_LAST) ? '0 : ras_ptr_q + PTR_W'(1);
        if (ras_occ_q != OCC_FULL) ras_occ_q <= ras_occ_q + OCC_W'(1);
      end else if (up_type == BR_RET && ras_occ_q != '0) begin
        ras_ptr_q <= ras_top_idx;
        ras_occ_q <= ras_occ_q - OCC_W'(1);
      end
    end
  end

  assign mispredict_cnt = mcnt_q;

endmodule
